// File: rtl/bloom_distinct_counter.sv
// Bloom-filter distinct-element counter: K multiplicative hashes into an M-bit filter, two-stage pipeline.
// Optional lookup-only queries are enabled by defining BFC_QUERY_EN.
module bloom_distinct_counter #(
    parameter int DATA_W  = 8,
    parameter int M_LOG2  = 8,
    parameter int K       = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_query,
    input  logic               clear,
    output logic               res_valid,
    output logic               res_hit,
    output logic [COUNT_W-1:0] count,
    output logic               saturated,
    output logic               busy
);

    localparam int M  = 1 << M_LOG2;
    localparam int NW = 1 << (M_LOG2 - 5);
    localparam int IW = (M_LOG2 > 5) ? M_LOG2 - 5 : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t             state;
    logic [M-1:0]       filter;
    logic               h_valid;
    logic               h_query;
    logic [M_LOG2-1:0]  h_idx    [K];
    logic [M_LOG2-1:0]  hash_idx [K];
    logic [31:0]        prod     [K];
    logic [IW-1:0]      clr_idx;
    logic [M_LOG2-1:0]  clr_base;
    logic               query_eff;
    logic               accept;
    logic               hit;
    logic [COUNT_W-1:0] count_inc;

    function automatic logic [31:0] hash_const(input int unsigned i);
        case (i)
            0:       return 32'h9E3779B1;
            1:       return 32'h85EBCA77;
            2:       return 32'hC2B2AE3D;
            default: return 32'h27D4EB2F;
        endcase
    endfunction

`ifdef BFC_QUERY_EN
    assign query_eff = in_query;
`else
    // Port kept for drop-in compatibility; every item inserts.
    assign query_eff = in_query & 1'b0;
`endif

    assign in_ready  = (state == IDLE) && !clear;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign count_inc = count + 1'b1;
    assign clr_base  = M_LOG2'({clr_idx, 5'b0});

    always_comb begin
        for (int unsigned i = 0; i < unsigned'(K); i++) begin
            prod[i]     = 32'(in_data) * hash_const(i);
            hash_idx[i] = prod[i][31 -: M_LOG2];
        end
    end

    always_comb begin
        hit = 1'b1;
        for (int unsigned i = 0; i < unsigned'(K); i++) begin
            hit = hit & filter[h_idx[i]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            filter    <= '0;
            h_valid   <= 1'b0;
            h_query   <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(K); i++) h_idx[i] <= '0;
            clr_idx   <= '0;
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            count     <= '0;
            saturated <= 1'b0;
        end else begin
            h_valid <= accept;
            if (accept) begin
                h_query <= query_eff;
                for (int unsigned i = 0; i < unsigned'(K); i++) h_idx[i] <= hash_idx[i];
            end

            // Filter read and write both happen here, so the next item sees this update.
            res_valid <= h_valid;
            if (h_valid) begin
                res_hit <= hit;
                if (!h_query && !hit) begin
                    for (int unsigned i = 0; i < unsigned'(K); i++) filter[h_idx[i]] <= 1'b1;
                    if (count != '1) begin
                        count <= count_inc;
                        if (count_inc == '1) saturated <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (clear) begin
                        state   <= h_valid ? DRAIN : CLEAR;
                        clr_idx <= '0;
                    end
                end
                DRAIN: state <= CLEAR;
                CLEAR: begin
                    filter[clr_base +: 32] <= '0;
                    if (clr_idx == '0) begin
                        count     <= '0;
                        saturated <= 1'b0;
                    end
                    if (clr_idx == IW'(NW - 1)) state <= IDLE;
                    clr_idx <= clr_idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bloom_distinct_counter.sv
// Directed bench for bloom_distinct_counter: default instance plus a COUNT_W=2 instance for saturation.
module tb_bloom_distinct_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_query, clear;
    logic [7:0]  in_data;
    logic        in_ready, res_valid, res_hit, saturated, busy;
    logic [15:0] count;

    logic        b_in_valid, b_in_query, b_clear;
    logic [7:0]  b_in_data;
    logic        b_in_ready, b_res_valid, b_res_hit, b_saturated, b_busy;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic        query;
        logic        hit;
        logic [15:0] cnt;
        logic        chk_sat;
        logic        sat;
    } vec_t;

    vec_t vec [6];

    always #5 clk = ~clk;

    bloom_distinct_counter #(.DATA_W(8), .M_LOG2(8), .K(2), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_query(in_query), .clear(clear),
        .res_valid(res_valid), .res_hit(res_hit), .count(count),
        .saturated(saturated), .busy(busy)
    );

    bloom_distinct_counter #(.DATA_W(8), .M_LOG2(8), .K(2), .COUNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_query(b_in_query), .clear(b_clear),
        .res_valid(b_res_valid), .res_hit(b_res_hit), .count(b_count),
        .saturated(b_saturated), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Items go in back-to-back; item i's result is checked two cycles after it is driven.
    task automatic run_table(input int n, input bit use_b);
        logic        rv, rh, rdy, sat;
        logic [15:0] cnt;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (use_b) begin
                rv = b_res_valid; rh = b_res_hit; rdy = b_in_ready;
                cnt = 16'(b_count); sat = b_saturated;
            end else begin
                rv = res_valid; rh = res_hit; rdy = in_ready;
                cnt = count; sat = saturated;
            end
            if (i == 1) check("latency_no_early_valid", 32'(rv), 32'd0);
            if (i >= 2) begin
                check("res_valid", 32'(rv), 32'd1);
                check("res_hit", 32'(rh), 32'(vec[i-2].hit));
                check("count", 32'(cnt), 32'(vec[i-2].cnt));
                if (vec[i-2].chk_sat) check("saturated", 32'(sat), 32'(vec[i-2].sat));
            end
            if (i < n) begin
                check("in_ready_stream", 32'(rdy), 32'd1);
                if (use_b) begin
                    b_in_valid = 1'b1; b_in_data = vec[i].data; b_in_query = vec[i].query;
                end else begin
                    in_valid = 1'b1; in_data = vec[i].data; in_query = vec[i].query;
                end
            end else begin
                if (use_b) b_in_valid = 1'b0;
                else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("res_valid_idle", 32'(use_b ? b_res_valid : res_valid), 32'd0);
    endtask

    initial begin
        int acc;
        int acc_at;
        reset = 1'b1;
        in_valid = 1'b0; in_query = 1'b0; clear = 1'b0; in_data = '0;
        b_in_valid = 1'b0; b_in_query = 1'b0; b_clear = 1'b0; b_in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_saturated", 32'(saturated), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_hit", 32'(res_hit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Stream 1,2,1: hashes {9E,85}, {3C,0B}, then a repeat.
        vec[0] = '{8'd1, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
        vec[1] = '{8'd2, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
        vec[2] = '{8'd1, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0};
        run_table(3, 1'b0);

`ifdef BFC_QUERY_EN
        vec[0] = '{8'd3, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        vec[1] = '{8'd3, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
        vec[2] = '{8'd3, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0};
        run_table(3, 1'b0);
`endif

        // Two-bit counter saturation.
        vec[0] = '{8'd0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
        vec[1] = '{8'd1, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
        vec[2] = '{8'd2, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0};
        vec[3] = '{8'd3, 1'b0, 1'b0, 16'd3, 1'b1, 1'b1};
        run_table(4, 1'b1);

        // Clear with an item in stage H (drain) and a competing item 5.
        @(negedge clk); in_valid = 1'b1; in_data = 8'd1; in_query = 1'b0;
        @(negedge clk); in_data = 8'd2;
        @(negedge clk); in_data = 8'd5; clear = 1'b1;
        #1;
        check("clear_cycle_in_ready", 32'(in_ready), 32'd0);
        check("clear_cycle_busy", 32'(busy), 32'd0);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear = (j == 2);
            #1;
            check("clear_busy", 32'(busy), 32'd1);
            check("clear_in_ready", 32'(in_ready), 32'd0);
            if (j >= 1) check("clear_no_accept", 32'(res_valid), 32'd0);
        end
        @(negedge clk); clear = 1'b0;
        #1;
        check("clear_done_in_ready", 32'(in_ready), 32'd1);
        check("clear_done_busy", 32'(busy), 32'd0);
        check("clear_count", 32'(count), 32'd0);
        check("clear_saturated", 32'(saturated), 32'd0);
        vec[0] = '{8'd1, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
        run_table(1, 1'b0);

        // Reset during CLEAR word 3.
        @(negedge clk); clear = 1'b1;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk); clear = 1'b0;
        end
        @(negedge clk);
        #1;
        check("mid_clear_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_hit", 32'(res_hit), 32'd0);
        check("mid_rst_saturated", 32'(saturated), 32'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        vec[0] = '{8'd2, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
        vec[1] = '{8'd1, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
        run_table(2, 1'b0);

        // Back-pressure: item 7 held through a clear, accepted exactly once.
        @(negedge clk); clear = 1'b1; in_valid = 1'b1; in_data = 8'd7; in_query = 1'b0;
        acc = 0; acc_at = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (in_valid && in_ready) begin
                acc++;
                acc_at = k;
            end
            @(negedge clk);
            clear = 1'b0;
            if (acc > 0) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_accept_count", 32'(acc), 32'd1);
        check("bp_accept_cycle", 32'(acc_at), 32'd9);
        check("bp_count", 32'(count), 32'd1);
        check("bp_res_hit", 32'(res_hit), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
